calc_ctrl: RTL
==============

// Module: calc_ctrl
// PURPOSE
//  Control unit for the smallCALC datapath. A Moore FSM that sequences one
//  calculator operation per go request:
//   - load operand A, then operand B, into the register file;
//   - compute A op B into the result register;
//   - present the result on the datapath output.
//  Sits directly upstream of the datapath and drives its entire control
//  word (s1, wa, we, raa, rea, rab, reb, c, s2).
//  Accumulate mode chains operations: the previous result is used as A.
// PARAMETERS
//  RA_ADDR   2'd1  register-file address holding operand A
//  RB_ADDR   2'd2  register-file address holding operand B
//  RR_ADDR   2'd3  register-file address holding the result
//  OUT_HOLD  4     cycles the result is shown in SHOW; legal 1..255
// PORTS
//  clk    in   1  rising-edge clock
//  rst    in   1  synchronous reset, active-high
//  go     in   1  start request; sampled only in IDLE
//  op     in   2  ALU opcode; latched into op_q when go is accepted
//  acc    in   1  accumulate mode; latched into acc_q when go is accepted
//  s1     out  2  input-mux select: 00 in1, 01 in2, 10 zero, 11 aluout
//  wa     out  2  register-file write address
//  we     out  1  register-file write enable
//  raa    out  2  register-file read address, port A
//  rea    out  1  register-file read enable, port A
//  rab    out  2  register-file read address, port B
//  reb    out  1  register-file read enable, port B
//  c      out  2  ALU opcode (always driven from op_q)
//  s2     out  1  output-mux select: 0 aluout, 1 zero
//  busy   out  1  high in every state except IDLE
//  done   out  1  one-cycle pulse in the last SHOW cycle
//  cs     out  3  current state encoding, for debug
// BEHAVIOUR
//  State encoding: IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, SHOW=4.
//  Unused codes 5..7 go to IDLE on the next edge.
//  All outputs are decoded from the state register only (Moore).
//  Register-file reads are combinational; writes occur on the clk edge.
//  Default control word (IDLE):
//   s1=00, wa=00, we=0, raa=00, rea=0, rab=00, reb=0, c=op_q, s2=1.
//   The datapath output is therefore forced to zero in IDLE.
//  Reset: state=IDLE, op_q=00, acc_q=0, hold count=0.
//   Outputs take the IDLE word; busy=0, done=0.
//  Per-state controls (any field not listed keeps its IDLE value):
//   IDLE:    go=1 -> latch op and acc.
//            Next state: LOAD_B if acc=1, else LOAD_A.
//   LOAD_A:  s1=00, wa=RA_ADDR, we=1 -> LOAD_B.
//   LOAD_B:  s1=01, wa=RB_ADDR, we=1 -> COMPUTE.
//   COMPUTE: rea=1, raa = acc_q ? RR_ADDR : RA_ADDR; reb=1, rab=RB_ADDR;
//            s1=11, wa=RR_ADDR, we=1 -> SHOW. Clears the hold count.
//   SHOW:    rea=1, raa=RR_ADDR, reb=1, rab=RB_ADDR, s2=0, we=0.
//            Count increments each cycle.
//            On count==OUT_HOLD-1: done=1, next state IDLE.
//  SHOW output semantics: out equals ALU(op_q, R[RR], R[RB]). For a faithful
//   display the bench uses an opcode whose result is stable under re-apply,
//   or checks out against that expression.
//  Latency: go accepted at edge k -> LOAD_A (or LOAD_B when acc=1) is visible
//   in cycle k+1. A non-acc operation spans 3+OUT_HOLD busy cycles.
//  Boundary conditions:
//   - go while busy is ignored; it is not queued.
//   - op/acc changes while busy have no effect; c stays at op_q.
//   - go held high: exactly one IDLE cycle between back-to-back operations.
//   - rst in any state -> IDLE on the next edge; we=0 from that cycle on.
//     No partial write completes after the reset edge.
//   - acc=1 immediately after reset uses R[RR], whose content is undefined.
//     The controller does not guard this case.
// TESTING
//  1. rst=1 for 2 cycles -> cs=0, we=0, s2=1, busy=0, done=0, c=00.
//  2. go=1, op=01, acc=0 (OUT_HOLD=4) -> cs sequence 1,2,3,4,4,4,4,0.
//     we=1 only in cs 1..3; done high only in the 4th SHOW cycle;
//     c=01 throughout.
//  3. With datapath attached, in1=3, in2=2, op=00, acc=0 -> R1=3, R2=2,
//     R3=ALU(00,3,2); out is nonzero only during SHOW.
//  4. Second go with acc=1, in2=1 -> cs 2,3,4..; COMPUTE drives raa=3, wa=3;
//     R3 updates to ALU(op, old R3, 1).
//  5. Pulse go and flip op to 10 during LOAD_B -> c stays at latched value;
//     a go during SHOW is ignored.
//  6. Assert rst while in COMPUTE -> next cycle cs=0, we=0, busy=0;
//     R3 is not written on that edge.

Source files
------------

// File: rtl/calc_ctrl.sv
// Moore sequencer for the smallCALC datapath: loads A and B, computes A op B,
// then shows the result for OUT_HOLD cycles. Accumulate mode reuses the result as A.
module calc_ctrl #(
  parameter logic [1:0] RA_ADDR  = 2'd1,
  parameter logic [1:0] RB_ADDR  = 2'd2,
  parameter logic [1:0] RR_ADDR  = 2'd3,
  parameter int         OUT_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op,
  input  logic       acc,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic       rea,
  output logic [1:0] rab,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [2:0] cs
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    SHOW    = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
    logic       busy;
    logic       done;
    logic [2:0] cs;
  } ctrl_t;

  localparam logic [7:0] HOLD_LAST = 8'(OUT_HOLD - 1);

  state_t     state, state_n;
  logic [1:0] op_q, op_n;
  logic       acc_q, acc_n;
  logic [7:0] cnt, cnt_n;
  ctrl_t      ctrl_q;

  // Control word seen while sitting in state s with the given latched context.
  function automatic ctrl_t decode(state_t s, logic [1:0] o, logic a, logic [7:0] n);
    ctrl_t d;
    d      = '0;
    d.c    = o;
    d.s2   = 1'b1;
    d.cs   = s;
    d.busy = (s != IDLE);
    case (s)
      LOAD_A: begin
        d.s1 = 2'b00;
        d.wa = RA_ADDR;
        d.we = 1'b1;
      end
      LOAD_B: begin
        d.s1 = 2'b01;
        d.wa = RB_ADDR;
        d.we = 1'b1;
      end
      COMPUTE: begin
        d.rea = 1'b1;
        d.raa = a ? RR_ADDR : RA_ADDR;
        d.reb = 1'b1;
        d.rab = RB_ADDR;
        d.s1  = 2'b11;
        d.wa  = RR_ADDR;
        d.we  = 1'b1;
      end
      SHOW: begin
        d.rea  = 1'b1;
        d.raa  = RR_ADDR;
        d.reb  = 1'b1;
        d.rab  = RB_ADDR;
        d.s2   = 1'b0;
        d.done = (n == HOLD_LAST);
      end
      default: ;
    endcase
    return d;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = IDLE;
    op_n    = op_q;
    acc_n   = acc_q;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        state_n = IDLE;
        if (go) begin
          op_n    = op;
          acc_n   = acc;
          state_n = acc ? LOAD_B : LOAD_A;
        end
      end
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = COMPUTE;
      COMPUTE: begin
        state_n = SHOW;
        cnt_n   = 8'd0;
      end
      SHOW: begin
        cnt_n   = cnt + 8'd1;
        state_n = (cnt == HOLD_LAST) ? IDLE : SHOW;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the control word is registered from the next-state values, so the
  // outputs are glitch-free flops yet always equal decode(current state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      acc_q  <= 1'b0;
      cnt    <= 8'd0;
      ctrl_q <= decode(IDLE, 2'b00, 1'b0, 8'd0);
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      acc_q  <= acc_n;
      cnt    <= cnt_n;
      ctrl_q <= decode(state_n, op_n, acc_n, cnt_n);
    end
  end

  assign s1   = ctrl_q.s1;
  assign wa   = ctrl_q.wa;
  // Masking with rst keeps the register file from capturing on the reset edge itself.
  assign we   = ctrl_q.we & ~rst;
  assign raa  = ctrl_q.raa;
  assign rea  = ctrl_q.rea;
  assign rab  = ctrl_q.rab;
  assign reb  = ctrl_q.reb;
  assign c    = ctrl_q.c;
  assign s2   = ctrl_q.s2;
  assign busy = ctrl_q.busy;
  assign done = ctrl_q.done;
  assign cs   = ctrl_q.cs;

endmodule
